// File: rtl/fddr_out_sched.sv
// Burst scheduler feeding one DDR output cell: FIFO-buffered words framed by preamble/postamble.
// Optional link training is compiled in when FDDR_OUT_SCHED_TRAIN_EN is defined.
module fddr_out_sched #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PRE_LEN   = 2,
  parameter int unsigned POST_LEN  = 1,
  parameter int unsigned TRAIN_LEN = 8
) (
  input  logic c,
  input  logic clr_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_d0,
  input  logic in_d1,
  input  logic in_last,
  input  logic train_req,
  output logic train_ack,
  output logic d0,
  output logic d1,
  output logic ce,
  output logic r,
  output logic s,
  output logic busy,
  output logic underrun
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW = AW + 1;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic d0;
    logic d1;
    logic last;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_POST
`ifdef FDDR_OUT_SCHED_TRAIN_EN
    , ST_TRAIN
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] count_q;
  logic          push_c, pop_c, fifo_empty_c;
  entry_t        head_c;

  logic d0_d, d1_d, ce_d, r_d, s_d, busy_d, und_d, ack_d;

`ifndef FDDR_OUT_SCHED_TRAIN_EN
  logic unused_train;
  assign unused_train = ^{train_req, CW'(TRAIN_LEN)};
`endif

  // FIFO occupancy and handshake
  assign fifo_empty_c = (count_q == '0);
  assign in_ready     = (count_q != NW'(DEPTH));
  assign push_c       = in_valid && in_ready;
  assign head_c       = mem[rd_ptr_q];
  assign pop_c        = (state_d == ST_DATA) && !fifo_empty_c;

  always_ff @(posedge c) begin
    if (push_c) mem[wr_ptr_q] <= {in_d0, in_d1, in_last};
  end

  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_c && !pop_c)      count_q <= count_q + NW'(1);
      else if (!push_c && pop_c) count_q <= count_q - NW'(1);
    end
  end

  // State register
  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next state; phase counter loads on entry and stops at its terminal value of 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cnt_q > CW'(1)) cnt_d = cnt_q - CW'(1);
    case (state_q)
      ST_IDLE: begin
`ifdef FDDR_OUT_SCHED_TRAIN_EN
        if (train_req) begin
          state_d = ST_TRAIN;
          cnt_d   = CW'(TRAIN_LEN);
        end else
`endif
        if (!fifo_empty_c) begin
          state_d = ST_PRE;
          cnt_d   = CW'(PRE_LEN);
        end
      end
      ST_PRE: begin
        if (cnt_q == CW'(1)) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (last_q) begin
          state_d = ST_POST;
          cnt_d   = CW'(POST_LEN);
        end
      end
      ST_POST: begin
        if (cnt_q == CW'(1)) state_d = ST_IDLE;
      end
`ifdef FDDR_OUT_SCHED_TRAIN_EN
      ST_TRAIN: begin
        if (cnt_q == CW'(1)) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Cell outputs for the upcoming cycle; a starved DATA cycle holds D0/D1 and drops CE
  always_comb begin
    d0_d   = d0;
    d1_d   = d1;
    ce_d   = 1'b1;
    r_d    = 1'b0;
    s_d    = 1'b0;
    und_d  = 1'b0;
    last_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
`ifdef FDDR_OUT_SCHED_TRAIN_EN
    ack_d  = (state_q == ST_TRAIN) && (state_d == ST_IDLE);
`else
    ack_d  = 1'b0;
`endif
    case (state_d)
      ST_IDLE: begin
        d0_d = 1'b0;
        d1_d = 1'b0;
        r_d  = 1'b1;
      end
      ST_DATA: begin
        if (pop_c) begin
          d0_d   = head_c.d0;
          d1_d   = head_c.d1;
          last_d = head_c.last;
        end else begin
          ce_d  = 1'b0;
          und_d = 1'b1;
        end
      end
      ST_POST: begin
        d0_d = 1'b0;
        d1_d = 1'b1;
      end
      default: begin
        d0_d = 1'b1;
        d1_d = 1'b0;
      end
    endcase
  end

  // Output register; reset pins park the cell low with CE off
  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      d0        <= 1'b0;
      d1        <= 1'b0;
      ce        <= 1'b0;
      r         <= 1'b1;
      s         <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      train_ack <= 1'b0;
    end else begin
      d0        <= d0_d;
      d1        <= d1_d;
      ce        <= ce_d;
      r         <= r_d;
      s         <= s_d;
      busy      <= busy_d;
      underrun  <= und_d;
      train_ack <= ack_d;
    end
  end

endmodule

// File: doc/fddr_out_sched.md
# fddr_out_sched

- Burst scheduler for one DDR output cell with sync/async set-reset and clock enable.
- Buffers 2-bit DDR words (rising-half D0, falling-half D1) from a valid/ready stream and frames each burst with a preamble and postamble.
- Arbitrates between the data stream and an optional link-training requester.
- Drives the cell's D0, D1, CE, R, S pins one cycle per word; the cell sits directly downstream on C0 = C, C1 = ~C.

## Interface

Parameters:
- DEPTH, 4 — FIFO entries; power of two, ≥ 2.
- PRE_LEN, 2 — preamble cycles, 1..15.
- POST_LEN, 1 — postamble cycles, 1..15.
- TRAIN_LEN, 8 — training cycles, 1..255.

Ports:
- C  in  1  clock, rising edge.
- CLR_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  upstream word valid.
- IN_READY  out  1  FIFO not full (combinational from occupancy).
- IN_D0  in  1  rising-half bit.
- IN_D1  in  1  falling-half bit.
- IN_LAST  in  1  final word of burst.
- TRAIN_REQ  in  1  training request, level.
- TRAIN_ACK  out  1  one-cycle pulse, training complete.
- D0, D1  out  1 each  to the cell.
- CE  out  1  to the cell.
- R  out  1  to the cell (forces output low).
- S  out  1  to the cell (forces output high).
- BUSY  out  1  state ≠ IDLE.
- UNDERRUN  out  1  one-cycle pulse per starved DATA cycle.

## Operation

- FIFO:
  - Entries are {D0, D1, LAST}.
  - Write on IN_VALID & IN_READY.
  - Read only in DATA when non-empty.
  - Simultaneous read and write when full is not permitted; IN_READY is low when full.
- States and cell outputs, as {D0, D1, CE, R, S}:
  - IDLE {0,0,1,1,0}.
  - PRE {1,0,1,0,0}.
  - DATA {fifo D0, fifo D1, 1, 0, 0}.
  - Underrun inside DATA {hold, hold, 0, 0, 0}; the cell holds its last value.
  - POST {0,1,1,0,0}.
  - TRAIN {1,0,1,0,0}.
- Transitions:
  - IDLE→TRAIN if TRAIN_REQ. Training wins over a non-empty FIFO.
  - Else IDLE→PRE if the FIFO is non-empty.
  - PRE→DATA after PRE_LEN cycles.
  - In DATA, pop one entry per cycle. A popped entry with LAST=1 → POST.
  - DATA with an empty FIFO: stay in DATA, CE=0, UNDERRUN=1 for that cycle.
  - POST→IDLE after POST_LEN cycles.
  - TRAIN→IDLE after TRAIN_LEN cycles; TRAIN_ACK=1 in the cycle IDLE is entered.
- TRAIN_REQ is sampled only in IDLE. A request raised mid-burst waits for the return to IDLE.
- Phase counter is 8 bits, loaded on state entry, with terminal detect at 1. It never wraps.
- R and S are never both 1.

## Timing

- All outputs except IN_READY are registered.
- Reset values:
  - D0=0, D1=0, CE=0, R=1, S=0.
  - TRAIN_ACK=0, BUSY=0, UNDERRUN=0.
  - FIFO empty; IN_READY=1 once CLR_N is high.
  - First rising edge after reset loads the IDLE outputs (CE=1).
- Latency, word accepted at edge N with the block in IDLE and the FIFO empty:
  - PRE outputs appear at edge N+1.
  - First data word appears at edge N+1+PRE_LEN.
- Throughput is one word per cycle, sustained.
- Burst of K words with no starvation occupies the cell for PRE_LEN+K+POST_LEN cycles, then IDLE.
- A back-to-back burst already in the FIFO starts PRE on the cycle after POST ends. The IDLE state lasts exactly one cycle.
- Reset asserted mid-burst:
  - All outputs return to reset values immediately.
  - FIFO contents are discarded.
  - No TRAIN_ACK is issued.

## Configuration

- FDDR_OUT_SCHED_TRAIN_EN defined:
  - TRAIN state, counter use and TRAIN_ACK are compiled in, as described above.
- FDDR_OUT_SCHED_TRAIN_EN undefined:
  - TRAIN state is absent and TRAIN_REQ is ignored.
  - TRAIN_ACK is tied to 0.
  - IDLE→PRE depends only on FIFO occupancy.

## Test plan

- Reset with CLR_N low for 3 cycles, then release → D0=0, D1=0, CE=0, R=1, S=0, IN_READY=1; one edge later CE=1, BUSY=0.
- Single word {1,1,LAST} at edge N, PRE_LEN=2 → {1,0} at N+1 and N+2, {1,1} at N+3, {0,1} at N+4, IDLE at N+5.
- 4-word burst with a 2-cycle IN_VALID gap after word 2 → two cycles of CE=0 with UNDERRUN=1; the remaining words follow in order; POST then IDLE.
- IN_VALID held high with 6 words and DEPTH=4 while the block is still in PRE → IN_READY drops once 4 entries are held; no word is lost or duplicated at the cell.
- With FDDR_OUT_SCHED_TRAIN_EN defined, TRAIN_REQ and a non-empty FIFO together in IDLE, TRAIN_LEN=8 → 8 cycles of {1,0}, TRAIN_ACK pulses once, then PRE of the pending burst. With the macro undefined → PRE immediately and TRAIN_ACK stays 0.
- CLR_N pulsed low during DATA → R=1 and CE=0 asynchronously, FIFO empty; a subsequent new burst is delivered correctly.
